muldiv_seq: RTL and testbench
=============================

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter N, default 64, the operand/result width in bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port start_E, input, 1, request from the execute stage to begin an M-op.
REQ-005 SHALL have port op_E, input, 2, the operation: 00 MUL (low N bits), 01 MULHU (high N bits unsigned), 10 DIVU, 11 REMU.
REQ-006 SHALL have port a_E, input, N, operand a (multiplicand or dividend).
REQ-007 SHALL have port b_E, input, N, operand b (multiplier or divisor).
REQ-008 SHALL have port flush, input, 1, pipeline flush; aborts any operation in flight.
REQ-009 SHALL have port stall_E, output, 1, holds the fetch, decode and execute pipeline registers.
REQ-010 SHALL have port busy, output, 1, high while state is not IDLE.
REQ-011 SHALL have port done, output, 1, one-cycle result-valid pulse.
REQ-012 SHALL have port result_E, output, N, the operation result.

Function
REQ-013 SHALL implement three FSM states: IDLE, RUN and DONE.
REQ-014 In IDLE, start_E=1 with flush=0 SHALL latch op_E, a_E and b_E, clear the iteration counter and go to RUN.
REQ-015 A divide-class op with b_E=0 SHALL go IDLE->DONE directly: DIVU result all-ones, REMU result a_E.
REQ-016 RUN SHALL perform exactly one iteration per cycle for N cycles, counter 0..N-1; at counter=N-1 it SHALL go to DONE.
REQ-017 MUL and MULHU SHALL use unsigned shift-add into a 2N-bit accumulator: MUL takes bits [N-1:0], MULHU takes bits [2N-1:N].
REQ-018 DIVU and REMU SHALL use restoring division, one quotient bit per iteration, MSB first; DIVU takes the quotient, REMU the remainder.
REQ-019 DONE SHALL last exactly one cycle with done=1 and result_E valid, then go to IDLE.
REQ-020 Latency SHALL be: start accepted at edge k, done=1 during the cycle after edge k+N+1; the zero-divisor case gives done after edge k+1.
REQ-021 result_E SHALL hold its value after DONE until the next DONE.
REQ-022 stall_E SHALL equal (start_E and state=IDLE and not flush) or state=RUN; it SHALL be 0 in DONE so the pipeline advances and captures result_E.
REQ-023 start_E while busy=1 SHALL be ignored; no re-latch and no restart.
REQ-024 flush=1 in any state SHALL force IDLE at the next edge, suppress done and leave result_E unchanged; flush has priority over start_E.
REQ-025 done and stall_E SHALL be 0 in IDLE without start_E.

Reset
REQ-026 reset SHALL asynchronously force state IDLE, counter 0 and accumulators 0, with busy=0, done=0, stall_E=0 and result_E=0.
REQ-027 reset asserted mid-RUN SHALL abandon the operation; no done pulse SHALL follow reset deassertion.

Structure
REQ-028 SHALL place the op encoding enum (MUL, MULHU, DIVU, REMU) and the FSM state enum in the shared package exec_pkg.
REQ-029 SHALL split into the FSM/counter (muldiv_seq) and one sub-module muldiv_dp holding the accumulators and iteration arithmetic, stepped by a step/init/op interface.
REQ-030 The counter SHALL be $clog2(N) bits wide; no other sub-modules.

Verification
REQ-031 Scenario: MUL a=3, b=5 -> done exactly N+1 cycles after the start edge, result_E=15, stall_E high for N+1 cycles.
REQ-032 Scenario: MULHU a=b=all-ones -> result_E = all-ones minus 1 (0xFFFF_FFFF_FFFF_FFFE at N=64).
REQ-033 Scenario: DIVU 100/7 -> 14; REMU 100/7 -> 2; start_E pulsed again mid-RUN -> ignored, results unchanged.
REQ-034 Scenario: DIVU a=42, b=0 -> all-ones one cycle after start; REMU a=42, b=0 -> 42; no RUN state entered.
REQ-035 Scenario: flush at RUN counter=10 -> IDLE next cycle, no done, result_E keeps the prior value; a new start then completes normally.
REQ-036 Scenario: reset pulsed asynchronously mid-RUN -> all outputs 0 immediately, no done afterwards.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared execute-stage types: M-op encoding and the sequential mul/div FSM states.
package exec_pkg;

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_MULHU = 2'b01,
    OP_DIVU  = 2'b10,
    OP_REMU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  function automatic logic op_is_div(input op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_dp.sv
// Mul/div datapath: 2N-bit accumulator stepped one shift-add or restoring-divide
// iteration per step; res_next_o is the result as it will be after the current step.
module muldiv_dp
  import exec_pkg::*;
#(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         init_i,
  input  logic         step_i,
  input  logic [1:0]   op_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] res_next_o
);

  op_e            op_q;
  logic [N-1:0]   opnd_q;
  logic [2*N-1:0] acc_q;

  logic [N:0]     mul_sum_s;
  logic [2*N-1:0] mul_next_s;
  logic [N:0]     div_rs_s;
  logic [N:0]     div_diff_s;
  logic           div_ge_s;
  logic [N-1:0]   div_rem_s;
  logic [2*N-1:0] div_next_s;
  logic [2*N-1:0] acc_step_s;

  // Multiply keeps {partial, multiplier} and shifts right; divide keeps {remainder, quotient} and shifts left.
  always_comb begin
    mul_sum_s  = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, opnd_q} : {(N+1){1'b0}});
    mul_next_s = {mul_sum_s, acc_q[N-1:1]};
    div_rs_s   = acc_q[2*N-1:N-1];
    div_ge_s   = (div_rs_s >= {1'b0, opnd_q});
    div_diff_s = div_rs_s - {1'b0, opnd_q};
    div_rem_s  = div_ge_s ? div_diff_s[N-1:0] : div_rs_s[N-1:0];
    div_next_s = {div_rem_s, acc_q[N-2:0], div_ge_s};
    acc_step_s = op_is_div(op_q) ? div_next_s : mul_next_s;
    res_next_o = op_q[0] ? acc_step_s[2*N-1:N] : acc_step_s[N-1:0];
  end

  // Operand latch on init, one iteration per step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q   <= OP_MUL;
      opnd_q <= {N{1'b0}};
      acc_q  <= {(2*N){1'b0}};
    end else if (init_i) begin
      op_q   <= op_e'(op_i);
      opnd_q <= op_i[1] ? b_i : a_i;
      acc_q  <= {{N{1'b0}}, (op_i[1] ? a_i : b_i)};
    end else if (step_i) begin
      acc_q  <= acc_step_s;
    end else begin
      acc_q  <= acc_q;
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Sequential M-extension unit for the execute stage: IDLE/RUN/DONE control with
// an N-cycle iteration counter, stalling the front of the pipeline while running.
module muldiv_seq
  import exec_pkg::*;
#(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_E,
  input  logic [1:0]   op_E,
  input  logic [N-1:0] a_E,
  input  logic [N-1:0] b_E,
  input  logic         flush,
  output logic         stall_E,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result_E
);

  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     result_q, result_d;
  logic             dp_init_s;
  logic             dp_step_s;
  logic [N-1:0]     dp_res_next_s;

  muldiv_dp #(.N(N)) u_dp (
    .clk        (clk),
    .reset      (reset),
    .init_i     (dp_init_s),
    .step_i     (dp_step_s),
    .op_i       (op_E),
    .a_i        (a_E),
    .b_i        (b_E),
    .res_next_o (dp_res_next_s)
  );

  // Next-state logic; flush overrides everything and leaves the result untouched.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    dp_init_s = 1'b0;
    dp_step_s = 1'b0;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_E) begin
            dp_init_s = 1'b1;
            cnt_d     = {CNT_W{1'b0}};
            if (op_E[1] && (b_E == {N{1'b0}})) begin
              state_d  = ST_DONE;
              result_d = op_E[0] ? a_E : {N{1'b1}};
            end else begin
              state_d = ST_RUN;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          dp_step_s = 1'b1;
          cnt_d     = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_q == CNT_LAST) begin
            state_d  = ST_DONE;
            result_d = dp_res_next_s;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, counter and held result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      result_q <= {N{1'b0}};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign stall_E  = (start_E && (state_q == ST_IDLE) && !flush) || (state_q == ST_RUN);
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign result_E = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq at N=64.
module tb_muldiv_seq;

  localparam int N = 64;

  logic         clk;
  logic         reset;
  logic         start_E;
  logic [1:0]   op_E;
  logic [N-1:0] a_E;
  logic [N-1:0] b_E;
  logic         flush;
  logic         stall_E;
  logic         busy;
  logic         done;
  logic [N-1:0] result_E;

  int checks = 0;
  int errors = 0;

  muldiv_seq #(.N(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .start_E  (start_E),
    .op_E     (op_E),
    .a_E      (a_E),
    .b_E      (b_E),
    .flush    (flush),
    .stall_E  (stall_E),
    .busy     (busy),
    .done     (done),
    .result_E (result_E)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op; optionally re-pulse start_E at cycle 'poke' while running.
  task automatic run_op(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                        input int poke, output int cyc, output int stall_cnt,
                        output logic [63:0] res, output logic stall_at_done,
                        output logic done_after, output logic [63:0] res_after);
    @(negedge clk);
    op_E = op; a_E = a; b_E = b; start_E = 1'b1;
    #1;
    stall_cnt = stall_E ? 1 : 0;
    cyc = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      start_E = 1'b0;
      if (cyc + 1 == poke) begin
        start_E = 1'b1; op_E = 2'b00; a_E = 64'd1; b_E = 64'd1;
      end
      #1;
      cyc++;
      if (done) break;
      if (stall_E) stall_cnt++;
    end
    start_E = 1'b0;
    res = result_E;
    stall_at_done = stall_E;
    @(negedge clk);
    #1;
    done_after = done;
    res_after = result_E;
  endtask

  int          cyc, scnt, dcnt;
  logic [63:0] res, res_after;
  logic        sdone, dafter;

  initial begin
    reset = 1'b1; start_E = 1'b0; op_E = 2'b00; a_E = '0; b_E = '0; flush = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_stall", 64'(stall_E), 64'd0);
    chk("rst_result", result_E, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_stall", 64'(stall_E), 64'd0);

    // MUL 3*5
    run_op(2'b00, 64'd3, 64'd5, 0, cyc, scnt, res, sdone, dafter, res_after);
    chk("mul_latency", 64'(cyc), 64'd65);
    chk("mul_result", res, 64'd15);
    chk("mul_stall_cycles", 64'(scnt), 64'd65);
    chk("mul_stall_in_done", 64'(sdone), 64'd0);
    chk("mul_done_one_cycle", 64'(dafter), 64'd0);
    chk("mul_result_hold", res_after, 64'd15);

    // MULHU and MUL of all-ones
    run_op(2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, cyc, scnt, res, sdone, dafter, res_after);
    chk("mulhu_ones", res, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("mulhu_latency", 64'(cyc), 64'd65);
    run_op(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, cyc, scnt, res, sdone, dafter, res_after);
    chk("mul_lo_ones", res, 64'd1);
    run_op(2'b01, 64'h1_0000_0000, 64'h3_0000_0005, 0, cyc, scnt, res, sdone, dafter, res_after);
    chk("mulhu_mixed", res, 64'd3);

    // DIVU/REMU 100/7 with a stray start mid-run
    run_op(2'b10, 64'd100, 64'd7, 20, cyc, scnt, res, sdone, dafter, res_after);
    chk("divu_100_7", res, 64'd14);
    chk("divu_latency_poke", 64'(cyc), 64'd65);
    chk("divu_busy_after", 64'(busy), 64'd0);
    run_op(2'b11, 64'd100, 64'd7, 30, cyc, scnt, res, sdone, dafter, res_after);
    chk("remu_100_7", res, 64'd2);
    chk("remu_latency_poke", 64'(cyc), 64'd65);
    run_op(2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, cyc, scnt, res, sdone, dafter, res_after);
    chk("divu_by_one", res, 64'hFFFF_FFFF_FFFF_FFFF);

    // Divide by zero skips RUN
    run_op(2'b10, 64'd42, 64'd0, 0, cyc, scnt, res, sdone, dafter, res_after);
    chk("divu_zero", res, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("divu_zero_latency", 64'(cyc), 64'd1);
    chk("divu_zero_no_run", 64'(scnt), 64'd1);
    run_op(2'b11, 64'd42, 64'd0, 0, cyc, scnt, res, sdone, dafter, res_after);
    chk("remu_zero", res, 64'd42);
    chk("remu_zero_latency", 64'(cyc), 64'd1);

    // Flush at counter=10
    @(negedge clk);
    op_E = 2'b00; a_E = 64'd3; b_E = 64'd5; start_E = 1'b1;
    @(negedge clk);
    start_E = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_done", 64'(done), 64'd0);
    chk("flush_result_kept", result_E, 64'd42);
    dcnt = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("flush_no_done", 64'(dcnt), 64'd0);
    run_op(2'b10, 64'd1000, 64'd10, 0, cyc, scnt, res, sdone, dafter, res_after);
    chk("after_flush_divu", res, 64'd100);
    chk("after_flush_latency", 64'(cyc), 64'd65);

    // Asynchronous reset mid-run
    @(negedge clk);
    op_E = 2'b00; a_E = 64'd7; b_E = 64'd6; start_E = 1'b1;
    @(negedge clk);
    start_E = 1'b0;
    repeat (20) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_stall", 64'(stall_E), 64'd0);
    chk("arst_result", result_E, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    chk("arst_no_done", 64'(dcnt), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
